// File: rtl/seq_ram_arb_pkg.sv
// Shared definitions for the sequencer RAM arbiter: arbitration modes,
// master index type and default RAM geometry.
package seq_ram_arb_pkg;

   localparam int ARB_RR     = 0;
   localparam int ARB_PRIO   = 1;

   localparam int DEF_ADDR_W = 9;
   localparam int DEF_DATA_W = 32;

   typedef logic mst_idx_t;

endpackage

// File: rtl/seq_ram_arb_grant.sv
// Two-master grant logic: round-robin or fixed priority with starvation guard.
// Produces a one-hot grant, forced to zero while reset_n is low.
module seq_ram_arb_grant
   import seq_ram_arb_pkg::*;
#(
   parameter int ARB_MODE     = ARB_RR,
   parameter int STARVE_LIMIT = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   mst_idx_t   last;
   logic [7:0] starve_cnt;
   logic [1:0] gnt_raw;

   always_comb begin
      gnt_raw = 2'b00;
      if (ARB_MODE == ARB_PRIO) begin
         // m1 wins only when m0 is idle or m1 has waited STARVE_LIMIT cycles
         if (req[1] && (!req[0] || (starve_cnt == 8'(STARVE_LIMIT)))) begin
            gnt_raw = 2'b10;
         end else if (req[0]) begin
            gnt_raw = 2'b01;
         end
      end else begin
         if (req == 2'b11) begin
            gnt_raw = last ? 2'b01 : 2'b10;
         end else begin
            gnt_raw = req;
         end
      end
   end

   assign gnt = gnt_raw & {2{reset_n}};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last       <= 1'b1;
         starve_cnt <= 8'd0;
      end else begin
         if (|gnt) begin
            last <= gnt[1];
         end
         if (ARB_MODE == ARB_PRIO) begin
            if (gnt[1]) begin
               starve_cnt <= 8'd0;
            end else if (req[1]) begin
               starve_cnt <= starve_cnt + 8'd1;
            end
         end
      end
   end

endmodule

// File: rtl/seq_ram_arbiter.sv
// Two-master arbiter for the single-port sequencer RAM with 1-cycle read return.
// Define SEQ_RAM_ARB_WPROT_EN to block m1 writes below PROT_LIMIT and add wprot_* ports.
module seq_ram_arbiter
   import seq_ram_arb_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int ARB_MODE     = ARB_RR,
`ifdef SEQ_RAM_ARB_WPROT_EN
   parameter int PROT_LIMIT   = 64,
`endif
   parameter int STARVE_LIMIT = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [ADDR_W-1:0]   m0_address,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [DATA_W-1:0]   m0_writedata,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   output logic                m0_readdatavalid,
   input  logic [ADDR_W-1:0]   m1_address,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [DATA_W-1:0]   m1_writedata,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic                m1_readdatavalid,
   output logic [ADDR_W-1:0]   ram_address,
   output logic [DATA_W/8-1:0] ram_byteenable,
   output logic                ram_chipselect,
   output logic                ram_write,
   output logic [DATA_W-1:0]   ram_writedata,
   output logic                ram_clken,
`ifdef SEQ_RAM_ARB_WPROT_EN
   output logic                wprot_err,
   output logic                wprot_seen,
`endif
   input  logic [DATA_W-1:0]   ram_readdata
);

   logic [1:0] req;
   logic [1:0] gnt;
   mst_idx_t   sel;
   logic       any_gnt;
   logic       g_write;
   logic       g_read;
   logic       blocked;
   logic       rd_pend;
   mst_idx_t   rd_src;

   // Read+write together is a protocol error and is served as a write
   assign req = {m1_read | m1_write, m0_read | m0_write};

   seq_ram_arb_grant #(
      .ARB_MODE     (ARB_MODE),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_grant (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req),
      .gnt     (gnt)
   );

   assign any_gnt        = |gnt;
   assign sel            = gnt[1];
   assign g_write        = sel ? m1_write : m0_write;
   assign g_read         = any_gnt & ~g_write;
   assign m0_waitrequest = ~gnt[0];
   assign m1_waitrequest = ~gnt[1];
   assign ram_clken      = 1'b1;

`ifdef SEQ_RAM_ARB_WPROT_EN
   assign blocked = gnt[1] & m1_write & (int'(m1_address) < PROT_LIMIT);
`else
   assign blocked = 1'b0;
`endif

   always_comb begin
      ram_chipselect = any_gnt & ~blocked;
      ram_write      = any_gnt & g_write & ~blocked;
      ram_address    = '0;
      ram_byteenable = '0;
      ram_writedata  = '0;
      if (gnt[0]) begin
         ram_address    = m0_address;
         ram_byteenable = m0_byteenable;
         ram_writedata  = m0_writedata;
      end else if (gnt[1]) begin
         ram_address    = m1_address;
         ram_byteenable = m1_byteenable;
         ram_writedata  = m1_writedata;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_pend <= 1'b0;
         rd_src  <= 1'b0;
      end else begin
         rd_pend <= g_read;
         rd_src  <= sel;
      end
   end

   assign m0_readdatavalid = rd_pend & ~rd_src;
   assign m1_readdatavalid = rd_pend & rd_src;
   assign m0_readdata      = m0_readdatavalid ? ram_readdata : '0;
   assign m1_readdata      = m1_readdatavalid ? ram_readdata : '0;

`ifdef SEQ_RAM_ARB_WPROT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wprot_err  <= 1'b0;
         wprot_seen <= 1'b0;
      end else begin
         wprot_err  <= blocked;
         wprot_seen <= wprot_seen | blocked;
      end
   end
`endif

endmodule

// File: tb/tb_seq_ram_arbiter.sv
// Directed bench for seq_ram_arbiter: round-robin instance with a RAM model,
// plus a fixed-priority instance (STARVE_LIMIT=4) for the starvation guard.
module tb_seq_ram_arbiter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;

   logic [8:0]  m0_address = '0, m1_address = '0;
   logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
   logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
   logic [31:0] m0_writedata = '0, m1_writedata = '0;
   logic        m0_waitrequest, m1_waitrequest;
   logic [31:0] m0_readdata, m1_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic [8:0]  ram_address;
   logic [3:0]  ram_byteenable;
   logic        ram_chipselect, ram_write, ram_clken;
   logic [31:0] ram_writedata;
   logic [31:0] ram_q = '0;
`ifdef SEQ_RAM_ARB_WPROT_EN
   logic        wprot_err, wprot_seen;
   logic        p_wprot_err, p_wprot_seen;
`endif

   logic        p_m0_read = 1'b0, p_m1_read = 1'b0;
   logic        p_m0_waitrequest, p_m1_waitrequest;
   logic [31:0] p_m0_readdata, p_m1_readdata;
   logic        p_m0_readdatavalid, p_m1_readdatavalid;
   logic [8:0]  p_ram_address;
   logic [3:0]  p_ram_byteenable;
   logic        p_ram_chipselect, p_ram_write, p_ram_clken;
   logic [31:0] p_ram_writedata;
   logic [31:0] p_ram_readdata = '0;

   logic [31:0] mem [0:511];

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- DUTs ----------------
   seq_ram_arbiter dut (
      .clk (clk), .reset_n (reset_n),
      .m0_address (m0_address), .m0_byteenable (m0_byteenable),
      .m0_read (m0_read), .m0_write (m0_write), .m0_writedata (m0_writedata),
      .m0_waitrequest (m0_waitrequest), .m0_readdata (m0_readdata),
      .m0_readdatavalid (m0_readdatavalid),
      .m1_address (m1_address), .m1_byteenable (m1_byteenable),
      .m1_read (m1_read), .m1_write (m1_write), .m1_writedata (m1_writedata),
      .m1_waitrequest (m1_waitrequest), .m1_readdata (m1_readdata),
      .m1_readdatavalid (m1_readdatavalid),
      .ram_address (ram_address), .ram_byteenable (ram_byteenable),
      .ram_chipselect (ram_chipselect), .ram_write (ram_write),
      .ram_writedata (ram_writedata), .ram_clken (ram_clken),
`ifdef SEQ_RAM_ARB_WPROT_EN
      .wprot_err (wprot_err), .wprot_seen (wprot_seen),
`endif
      .ram_readdata (ram_q)
   );

   seq_ram_arbiter #(.ARB_MODE (1), .STARVE_LIMIT (4)) u_p (
      .clk (clk), .reset_n (reset_n),
      .m0_address (9'd0), .m0_byteenable (4'hF),
      .m0_read (p_m0_read), .m0_write (1'b0), .m0_writedata (32'd0),
      .m0_waitrequest (p_m0_waitrequest), .m0_readdata (p_m0_readdata),
      .m0_readdatavalid (p_m0_readdatavalid),
      .m1_address (9'd1), .m1_byteenable (4'hF),
      .m1_read (p_m1_read), .m1_write (1'b0), .m1_writedata (32'd0),
      .m1_waitrequest (p_m1_waitrequest), .m1_readdata (p_m1_readdata),
      .m1_readdatavalid (p_m1_readdatavalid),
      .ram_address (p_ram_address), .ram_byteenable (p_ram_byteenable),
      .ram_chipselect (p_ram_chipselect), .ram_write (p_ram_write),
      .ram_writedata (p_ram_writedata), .ram_clken (p_ram_clken),
`ifdef SEQ_RAM_ARB_WPROT_EN
      .wprot_err (p_wprot_err), .wprot_seen (p_wprot_seen),
`endif
      .ram_readdata (p_ram_readdata)
   );

   // ---------------- RAM model: byte-enabled, 1-cycle read latency ----------------
   initial begin
      for (int i = 0; i < 512; i++) mem[i] = '0;
   end

   always @(posedge clk) begin
      if (ram_chipselect && ram_clken) begin
         if (ram_write) begin
            for (int b = 0; b < 4; b++) begin
               if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
            end
         end else begin
            ram_q <= mem[ram_address];
         end
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic mreq(input int idx, input logic rd, input logic wr, input logic [8:0] a,
                       input logic [31:0] d, input logic [3:0] be);
      if (idx == 0) begin
         m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
      end else begin
         m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
      end
   endtask

   task automatic idle();
      mreq(0, 1'b0, 1'b0, 9'd0, 32'd0, 4'h0);
      mreq(1, 1'b0, 1'b0, 9'd0, 32'd0, 4'h0);
   endtask

   task automatic do_write(input int idx, input logic [8:0] a, input logic [31:0] d,
                           input logic [3:0] be);
      mreq(idx, 1'b0, 1'b1, a, d, be);
      @(negedge clk);
      check("wr_accept", (idx == 0) ? m0_waitrequest : m1_waitrequest, 32'd0);
      check("wr_cs", {ram_chipselect, ram_write}, 32'd3);
      check("wr_addr", ram_address, a);
      next_cycle();
      idle();
   endtask

   task automatic do_read(input int idx, input logic [8:0] a, input logic [31:0] exp);
      mreq(idx, 1'b1, 1'b0, a, 32'd0, 4'h0);
      @(negedge clk);
      check("rd_accept", (idx == 0) ? m0_waitrequest : m1_waitrequest, 32'd0);
      next_cycle();
      idle();
      @(negedge clk);
      check("rd_valid", (idx == 0) ? m0_readdatavalid : m1_readdatavalid, 32'd1);
      check("rd_other_valid", (idx == 0) ? m1_readdatavalid : m0_readdatavalid, 32'd0);
      check("rd_data", (idx == 0) ? m0_readdata : m1_readdata, exp);
      next_cycle();
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      // Reset with both masters requesting
      idle();
      m0_read = 1'b1;
      m1_read = 1'b1;
      @(negedge clk);
      check("rst_m0_wait", m0_waitrequest, 32'd1);
      check("rst_m1_wait", m1_waitrequest, 32'd1);
      check("rst_cs", {ram_chipselect, ram_write}, 32'd0);
      check("rst_rdv", {m0_readdatavalid, m1_readdatavalid}, 32'd0);
      check("rst_rddata", m0_readdata | m1_readdata, 32'd0);
      check("rst_clken", ram_clken, 32'd1);
      next_cycle();
      reset_n = 1'b1;
      @(negedge clk);
      check("first_gnt_m0", m0_waitrequest, 32'd0);
      check("first_gnt_m1_wait", m1_waitrequest, 32'd1);
      next_cycle();
      idle();
      @(negedge clk);
      check("first_rdv_m0", m0_readdatavalid, 32'd1);
      check("first_rd_data", m0_readdata, 32'd0);
      next_cycle();

      // Basic write then read, and byte lanes
      do_write(0, 9'h010, 32'hDEADBEEF, 4'hF);
      do_read(0, 9'h010, 32'hDEADBEEF);
      do_write(0, 9'h020, 32'h0000_0000, 4'hF);
      do_write(0, 9'h020, 32'h11223344, 4'b0101);
      do_read(0, 9'h020, 32'h00220044);

      // Read and write asserted together behaves as a write, no read return
      mreq(0, 1'b1, 1'b1, 9'h022, 32'hCAFEF00D, 4'hF);
      @(negedge clk);
      check("rw_is_write", {ram_chipselect, ram_write}, 32'd3);
      next_cycle();
      idle();
      @(negedge clk);
      check("rw_no_rdv", m0_readdatavalid, 32'd0);
      next_cycle();
      do_read(0, 9'h022, 32'hCAFEF00D);

      // Round-robin with both masters reading continuously
      do_write(1, 9'h041, 32'hB1B1B1B1, 4'hF);
      do_write(0, 9'h040, 32'hA0A0A0A0, 4'hF);
      mreq(0, 1'b1, 1'b0, 9'h040, 32'd0, 4'h0);
      mreq(1, 1'b1, 1'b0, 9'h041, 32'd0, 4'h0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("rr_m1_wait", m1_waitrequest, (i % 2 == 0) ? 32'd0 : 32'd1);
         check("rr_m0_wait", m0_waitrequest, (i % 2 == 0) ? 32'd1 : 32'd0);
         if (i > 0) begin
            if (i % 2 == 1) begin
               check("rr_rdv_m1", {m1_readdatavalid, m0_readdatavalid}, 32'd2);
               check("rr_data_m1", m1_readdata, 32'hB1B1B1B1);
               check("rr_data_m0_zero", m0_readdata, 32'd0);
            end else begin
               check("rr_rdv_m0", {m1_readdatavalid, m0_readdatavalid}, 32'd1);
               check("rr_data_m0", m0_readdata, 32'hA0A0A0A0);
               check("rr_data_m1_zero", m1_readdata, 32'd0);
            end
         end
         next_cycle();
      end
      idle();
      @(negedge clk);
      check("rr_last_rdv_m0", {m1_readdatavalid, m0_readdatavalid}, 32'd1);
      check("rr_last_data", m0_readdata, 32'hA0A0A0A0);
      next_cycle();

`ifdef SEQ_RAM_ARB_WPROT_EN
      // Protected region: m1 write below PROT_LIMIT is swallowed
      do_write(0, 9'd5, 32'h55AA55AA, 4'hF);
      mreq(1, 1'b0, 1'b1, 9'd5, 32'hFFFFFFFF, 4'hF);
      @(negedge clk);
      check("wprot_accept", m1_waitrequest, 32'd0);
      check("wprot_cs", ram_chipselect, 32'd0);
      check("wprot_err_before", wprot_err, 32'd0);
      next_cycle();
      idle();
      @(negedge clk);
      check("wprot_err_pulse", wprot_err, 32'd1);
      check("wprot_seen_set", wprot_seen, 32'd1);
      next_cycle();
      @(negedge clk);
      check("wprot_err_clear", wprot_err, 32'd0);
      check("wprot_seen_sticky", wprot_seen, 32'd1);
      next_cycle();
      do_read(0, 9'd5, 32'h55AA55AA);
`endif
      do_write(1, 9'd64, 32'h64646464, 4'hF);
      do_read(1, 9'd64, 32'h64646464);

      // Reset while a read is outstanding drops the return
      mreq(0, 1'b1, 1'b0, 9'h010, 32'd0, 4'h0);
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      idle();
      @(negedge clk);
      check("midrst_rdv", {m1_readdatavalid, m0_readdatavalid}, 32'd0);
      next_cycle();
      reset_n = 1'b1;
      @(negedge clk);
      check("midrst_rdv_after", {m1_readdatavalid, m0_readdatavalid}, 32'd0);
      check("midrst_idle_wait", {m1_waitrequest, m0_waitrequest}, 32'd3);
      next_cycle();

      // Fixed priority: m1 forced on its 5th requesting cycle with STARVE_LIMIT=4
      p_m0_read = 1'b1;
      p_m1_read = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         check("prio_m1_wait", p_m1_waitrequest, (k == 5) ? 32'd0 : 32'd1);
         check("prio_m0_wait", p_m0_waitrequest, (k == 5) ? 32'd1 : 32'd0);
         check("prio_starve_cnt", u_p.u_grant.starve_cnt, 32'(k - 1));
         next_cycle();
      end
      p_m1_read = 1'b0;
      @(negedge clk);
      check("prio_starve_clear", u_p.u_grant.starve_cnt, 32'd0);
      check("prio_m0_back", p_m0_waitrequest, 32'd0);
      next_cycle();
      p_m0_read = 1'b0;
      next_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_ram_arbiter.md
Name: seq_ram_arbiter

Overview:
Two-master arbiter for the 512x32 single-port sequencer RAM (byte-enabled, 1-cycle read latency, clock-enabled).
- Master 0 is the sequencer CPU data port; master 1 is the debug/calibration-load master.
- Grants one access per cycle, drives the RAM port, and returns read data with readdatavalid to the master that issued the read.
- Sits between the sequencer interconnect and the RAM.

Parameters:
ADDR_W, 9, RAM word-address width
DATA_W, 32, RAM data width; byteenable width is DATA_W/8
ARB_MODE, 0, 0 = round-robin; 1 = fixed priority to m0 with starvation guard
STARVE_LIMIT, 8, ARB_MODE=1 only: consecutive blocked cycles before m1 is forced (1..255)
PROT_LIMIT, 64, optional feature only: m1 writes to word addresses below this value are blocked

Ports:
clk  in  1  sole clock
reset_n  in  1  asynchronous active-low reset
m{0,1}_address  in  ADDR_W  word address
m{0,1}_byteenable  in  DATA_W/8  write byte lanes
m{0,1}_read  in  1  read request
m{0,1}_write  in  1  write request
m{0,1}_writedata  in  DATA_W  write data
m{0,1}_waitrequest  out  1  high = request not accepted this cycle
m{0,1}_readdata  out  DATA_W  read data
m{0,1}_readdatavalid  out  1  one-cycle pulse, readdata valid
ram_address  out  ADDR_W  to RAM
ram_byteenable  out  DATA_W/8  to RAM
ram_chipselect  out  1  to RAM
ram_write  out  1  to RAM
ram_writedata  out  DATA_W  to RAM
ram_clken  out  1  to RAM, tied 1
ram_readdata  in  DATA_W  RAM q, valid 1 cycle after read address is sampled

Behaviour:
- Request: req_i = m_i_read | m_i_write. A master asserting both read and write is a protocol error; the access is treated as a write.
- Grant is combinational each cycle from the req vector and state. The granted master gets waitrequest=0. Every non-granted master gets waitrequest=1, including idle masters.
- RAM port follows the granted master combinationally: chipselect=1, write=m_write. With no grant: chipselect=0, write=0, address/byteenable/writedata = 0.
- Round-robin (ARB_MODE=0):
  - last register, reset 1.
  - If both masters request, grant the master other than last.
  - A single requester is always granted.
  - last updates to the granted index on each grant.
- Fixed priority (ARB_MODE=1):
  - m0 wins a conflict.
  - starve_cnt (8b, reset 0) increments each cycle m1 requests and is not granted, and clears when m1 is granted.
  - When starve_cnt == STARVE_LIMIT, m1 is granted over m0 in that cycle.
- Read return:
  - Registered pair (rd_pend, rd_src), reset 0/0, set by a granted read.
  - Next cycle: m{rd_src}_readdatavalid = 1 and m{rd_src}_readdata = ram_readdata.
  - The other master's readdata holds 0.
  - Back-to-back reads from either master are allowed: throughput 1 per cycle, latency exactly 1 cycle.
- Writes complete on the grant edge; no response is returned.
- Reset values: readdatavalid 0, readdata 0, waitrequest 1, chipselect 0, write 0, ram_clken 1.
- Reset asserted mid-read: the pending readdatavalid is discarded and never emitted.
- Simultaneous read grant and read return in the same cycle are independent; both proceed.

Optional Feature:
SEQ_RAM_ARB_WPROT_EN
- Defined:
  - An m1 write with address < PROT_LIMIT is accepted (waitrequest=0) but ram_chipselect is held 0, so RAM content is unchanged.
  - Output port wprot_err (1b, registered, reset 0) pulses high for one cycle after the blocked write.
  - Sticky output wprot_seen (reset 0) sets on any blocked write; it is cleared only by reset.
- Undefined: no protection logic and no wprot_* ports.

Decomposition:
- Package seq_ram_arb_pkg holds:
  - localparams ARB_RR=0 and ARB_PRIO=1
  - master index typedef (1b)
  - the default ADDR_W/DATA_W
- Sub-module seq_ram_arb_grant: pure grant logic plus last/starve_cnt state, outputting a one-hot grant.
- Top level holds the RAM muxing, read-return tracking and protection.

Test Plan:
- Reset: reset_n=0 with both masters requesting -> all waitrequest=1, chipselect=0, readdatavalid=0; releasing reset_n gives m0 the first round-robin grant.
- m0 write 0xDEADBEEF at addr 0x10 with byteenable 0xF, then m0 read addr 0x10 -> readdatavalid exactly 1 cycle after acceptance with 0xDEADBEEF; m1_readdatavalid stays 0.
- ARB_MODE=0, both masters reading continuously -> grants alternate m1,m0,m1...; each readdatavalid pulse is routed to the correct master with the correct data.
- ARB_MODE=1, STARVE_LIMIT=4, m0 requesting every cycle, m1 requesting -> m1 granted on its 5th cycle of requesting; starve_cnt returns to 0.
- Byte lanes: write 0x11223344 with byteenable 0b0101 over a word holding 0 -> read returns 0x00220044.
- With SEQ_RAM_ARB_WPROT_EN and PROT_LIMIT=64: m1 write to addr 5 -> accepted, wprot_err pulses once, readback of addr 5 unchanged; m1 write to addr 64 succeeds.
